// File: rtl/life_engine_if.sv
// rtl/life_engine_if.sv - seed/step/board signal bundle for life_engine
interface life_engine_if #(
   parameter int GEN_W = 8
);
   logic                   load;
   logic [7:0][7:0]        seed_in;
   logic                   run;
   logic                   step_tick;
   logic [7:0][7:0]        board_out;
   logic [GEN_W-1:0]       gen_count;
   logic                   busy;
   logic                   stable;
   logic                   extinct;

   modport master (
      output load, seed_in, run, step_tick,
      input  board_out, gen_count, busy, stable, extinct
   );

   modport slave (
      input  load, seed_in, run, step_tick,
      output board_out, gen_count, busy, stable, extinct
   );
endinterface

// File: rtl/life_engine.sv
// rtl/life_engine.sv - 8x8 Conway generation engine, one row per clock into a shadow board
// Define LIFE_TORUS_EN for toroidal edges; default treats cells beyond the board as dead.
module life_engine #(
   parameter int GEN_W = 8
) (
   input  logic          clk,
   input  logic          reset,
   life_engine_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

   state_t            state_q, state_d;
   logic [2:0]        row_q, row_d;
   logic [7:0][7:0]   board_q, board_d;
   logic [7:0][7:0]   shadow_q, shadow_d;
   logic [GEN_W-1:0]  gen_q, gen_d;
   logic              stable_q, stable_d;
   logic              extinct_q, extinct_d;

   logic [7:0]        up_row, cur_row, dn_row;

   // Row with one guard column on each side: bit 0 is column -1, bit 9 is column 8.
   function automatic logic [9:0] pad_row(input logic [7:0] r);
`ifdef LIFE_TORUS_EN
      return {r[0], r, r[7]};
`else
      return {1'b0, r, 1'b0};
`endif
   endfunction

   function automatic logic [7:0] next_row(input logic [7:0] up,
                                           input logic [7:0] cur,
                                           input logic [7:0] dn);
      logic [9:0] pu, pc, pd;
      logic [3:0] n;
      logic [7:0] res;
      pu  = pad_row(up);
      pc  = pad_row(cur);
      pd  = pad_row(dn);
      res = '0;
      for (int c = 0; c < 8; c++) begin
         n = 4'(pu[c]) + 4'(pu[c+1]) + 4'(pu[c+2])
           + 4'(pc[c])               + 4'(pc[c+2])
           + 4'(pd[c]) + 4'(pd[c+1]) + 4'(pd[c+2]);
         res[c] = (n == 4'd3) | (pc[c+1] & (n == 4'd2));
      end
      return res;
   endfunction

   always_comb begin
      cur_row = board_q[row_q];
`ifdef LIFE_TORUS_EN
      up_row  = board_q[row_q - 3'd1];
      dn_row  = board_q[row_q + 3'd1];
`else
      up_row  = (row_q == 3'd0) ? 8'h00 : board_q[row_q - 3'd1];
      dn_row  = (row_q == 3'd7) ? 8'h00 : board_q[row_q + 3'd1];
`endif
   end

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      board_d   = board_q;
      shadow_d  = shadow_q;
      gen_d     = gen_q;
      stable_d  = stable_q;
      extinct_d = extinct_q;

      case (state_q)
         IDLE: begin
            if (bus.run && bus.step_tick) begin
               state_d = COMPUTE;
               row_d   = 3'd0;
            end
         end
         COMPUTE: begin
            shadow_d[row_q] = next_row(up_row, cur_row, dn_row);
            row_d           = row_q + 3'd1;
            if (row_q == 3'd7) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            board_d   = shadow_q;
            gen_d     = gen_q + 1'b1;
            stable_d  = (shadow_q == board_q);
            extinct_d = (shadow_q == '0);
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A load aborts any generation in flight and beats a same-cycle commit or tick.
      if (bus.load) begin
         board_d   = bus.seed_in;
         gen_d     = '0;
         stable_d  = 1'b0;
         extinct_d = (bus.seed_in == '0);
         state_d   = IDLE;
         row_d     = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         row_q     <= 3'd0;
         board_q   <= '0;
         shadow_q  <= '0;
         gen_q     <= '0;
         stable_q  <= 1'b0;
         extinct_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         board_q   <= board_d;
         shadow_q  <= shadow_d;
         gen_q     <= gen_d;
         stable_q  <= stable_d;
         extinct_q <= extinct_d;
      end
   end

   assign bus.board_out = board_q;
   assign bus.gen_count = gen_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.stable    = stable_q;
   assign bus.extinct   = extinct_q;

endmodule

// File: tb/tb_life_engine.sv
// tb/tb_life_engine.sv - self-checking bench for life_engine against a cell-level Life model
module tb_life_engine;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   life_engine_if #(.GEN_W(8)) bus ();
   life_engine #(.GEN_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [7:0][7:0] m_board, m_next;
   logic [7:0]      m_gen;
   logic            m_stable, m_extinct;
   int              m_cnt;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0][7:0] life_step(input logic [7:0][7:0] b);
      logic [7:0][7:0] nb;
      int n, rr, cc;
      nb = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr == 0 && dc == 0) continue;
                  rr = r + dr;
                  cc = c + dc;
`ifdef LIFE_TORUS_EN
                  rr = (rr + 8) % 8;
                  cc = (cc + 8) % 8;
`else
                  if (rr < 0 || rr > 7 || cc < 0 || cc > 7) continue;
`endif
                  n += int'(b[rr][cc]);
               end
            end
            nb[r][c] = (n == 3) || (b[r][c] && n == 2);
         end
      end
      return nb;
   endfunction

   // Reference: a generation is decided when the tick is taken and lands 9 edges later.
   always @(posedge clk) begin
      if (reset) begin
         m_board = '0; m_gen = 0; m_stable = 0; m_extinct = 1; m_cnt = 0;
      end else if (bus.load) begin
         m_board = bus.seed_in; m_gen = 0; m_stable = 0;
         m_extinct = (bus.seed_in == '0); m_cnt = 0;
      end else if (m_cnt == 0) begin
         if (bus.run && bus.step_tick) begin
            m_cnt  = 9;
            m_next = life_step(m_board);
         end
      end else begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_stable  = (m_next == m_board);
            m_board   = m_next;
            m_gen     = m_gen + 8'd1;
            m_extinct = (m_next == '0);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("board_out", bus.board_out, m_board);
         cmp("gen_count", 64'(bus.gen_count), 64'(m_gen));
         cmp("busy",      64'(bus.busy),     64'(m_cnt != 0));
         cmp("stable",    64'(bus.stable),   64'(m_stable));
         cmp("extinct",   64'(bus.extinct),  64'(m_extinct));
      end
   end

   task automatic step();
      bus.step_tick = 1'b1;
      @(negedge clk);
      bus.step_tick = 1'b0;
   endtask

   task automatic load_seed(input logic [7:0][7:0] s);
      bus.seed_in = s;
      bus.load    = 1'b1;
      @(negedge clk);
      bus.load    = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (bus.busy && k < 20) begin
         @(negedge clk);
         k++;
      end
      cmp("idle_timeout", 64'(bus.busy), 64'(0));
   endtask

   logic [7:0][7:0] s_blk, s_blinker, e_blinker, s_lone, s_edge, e_edge;
   logic [63:0] rnd;

   initial begin
      reset = 1'b1;
      bus.load = 1'b0; bus.seed_in = '0; bus.run = 1'b0; bus.step_tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      cmp("rst_board",   bus.board_out, 64'(0));
      cmp("rst_gen",     64'(bus.gen_count), 64'(0));
      cmp("rst_extinct", 64'(bus.extinct), 64'(1));
      cmp("rst_busy",    64'(bus.busy), 64'(0));
      reset = 1'b0;
      @(negedge clk);

      s_blinker = '0; s_blinker[3] = 8'b00011100;
      e_blinker = '0; e_blinker[2] = 8'b00001000; e_blinker[3] = 8'b00001000; e_blinker[4] = 8'b00001000;
      s_blk = '0; s_blk[3] = 8'b00011000; s_blk[4] = 8'b00011000;
      s_lone = '0; s_lone[5] = 8'b00100000;
      s_edge = '0; s_edge[0] = 8'b00000111;
      e_edge = '0; e_edge[0] = 8'b00000010; e_edge[1] = 8'b00000010;
`ifdef LIFE_TORUS_EN
      e_edge[7] = 8'b00000010;
`endif
      cmp("model_blinker", life_step(s_blinker), e_blinker);
      cmp("model_block",   life_step(s_blk), s_blk);
      cmp("model_edge",    life_step(s_edge), e_edge);

      // Blinker with exact latency
      load_seed(s_blinker);
      cmp("load_visible", bus.board_out, s_blinker);
      bus.run = 1'b1;
      step();
      repeat (8) @(negedge clk);
      cmp("blinker_before_commit", bus.board_out, s_blinker);
      cmp("blinker_busy_commit", 64'(bus.busy), 64'(1));
      @(negedge clk);
      cmp("blinker_gen1", bus.board_out, e_blinker);
      cmp("blinker_cnt1", 64'(bus.gen_count), 64'(1));
      cmp("blinker_stable1", 64'(bus.stable), 64'(0));
      cmp("blinker_busy_done", 64'(bus.busy), 64'(0));
      step(); wait_idle();
      cmp("blinker_gen2", bus.board_out, s_blinker);
      cmp("blinker_cnt2", 64'(bus.gen_count), 64'(2));

      // Block still life
      load_seed(s_blk);
      step(); wait_idle();
      cmp("block_board", bus.board_out, s_blk);
      cmp("block_stable", 64'(bus.stable), 64'(1));
      cmp("block_extinct", 64'(bus.extinct), 64'(0));
      cmp("block_cnt", 64'(bus.gen_count), 64'(1));

      // Lone cell dies then stays dead
      load_seed(s_lone);
      step(); wait_idle();
      cmp("lone_board", bus.board_out, 64'(0));
      cmp("lone_extinct", 64'(bus.extinct), 64'(1));
      step(); wait_idle();
      cmp("lone_stable", 64'(bus.stable), 64'(1));
      cmp("lone_cnt", 64'(bus.gen_count), 64'(2));

      // Edge behaviour
      load_seed(s_edge);
      step(); wait_idle();
      cmp("edge_board", bus.board_out, e_edge);

      // Abort on load in the 4th compute cycle
      load_seed(s_blinker);
      step();
      repeat (3) @(negedge clk);
      load_seed(s_blk);
      cmp("abort_board", bus.board_out, s_blk);
      cmp("abort_cnt", 64'(bus.gen_count), 64'(0));
      cmp("abort_busy", 64'(bus.busy), 64'(0));

      // Tick while busy is dropped
      load_seed(s_blinker);
      step();
      repeat (2) @(negedge clk);
      step();
      wait_idle();
      repeat (12) @(negedge clk);
      cmp("busy_tick_cnt", 64'(bus.gen_count), 64'(1));
      cmp("busy_tick_board", bus.board_out, e_blinker);

      // Tick with run low
      bus.run = 1'b0;
      step();
      cmp("norun_busy", 64'(bus.busy), 64'(0));
      repeat (10) @(negedge clk);
      cmp("norun_cnt", 64'(bus.gen_count), 64'(1));
      bus.run = 1'b1;

      // Reset during compute
      step();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cmp("midrst_board", bus.board_out, 64'(0));
      cmp("midrst_cnt", 64'(bus.gen_count), 64'(0));
      cmp("midrst_extinct", 64'(bus.extinct), 64'(1));
      cmp("midrst_busy", 64'(bus.busy), 64'(0));
      load_seed(s_blinker);
      step(); wait_idle();
      cmp("post_rst_board", bus.board_out, e_blinker);
      cmp("post_rst_cnt", 64'(bus.gen_count), 64'(1));

      // Randomised traffic checked cycle by cycle against the model
      for (int i = 0; i < 4000; i++) begin
         rnd = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 0) rnd = rnd & {$urandom, $urandom};
         bus.seed_in   = rnd;
         bus.load      = ($urandom_range(0, 39) == 0);
         bus.run       = ($urandom_range(0, 3) != 0);
         bus.step_tick = ($urandom_range(0, 2) == 0);
         reset         = ($urandom_range(0, 499) == 0);
         @(negedge clk);
      end
      bus.load = 1'b0; bus.step_tick = 1'b0; reset = 1'b0;
      repeat (12) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
